n64_vdemux: RTL and testbench
=============================

# n64_vdemux

Front-end demultiplexer for the N64 7-bit video bus. It captures the sync nibble and the R, G and B words from the time-multiplexed stream framed by nDSYNC. It commits them as one parallel video word with a one-cycle nVDSYNC strobe, and derives the vmode (PAL/NTSC) and n64_480i (interlaced) flags from field line counts. It sits directly upstream of the post-processing stages (test pattern generator, scanline/deblur paths), which consume vdata_out, nVDSYNC and vmode.

## Interface
Parameters:
- color_width, 7, bits per colour channel on D_i and in vdata_out.
- vmode_thresh, 290, line count above which a field is classified PAL.
- min_field_lines, 200, fields with fewer lines are ignored for vmode and n64_480i.

Ports:
- VCLK  in  1  video clock; all logic is on its rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- nDSYNC  in  1  bus frame marker; low marks the sync-nibble cycle.
- D_i  in  color_width  N64 video data bus.
- nVDSYNC  out  1  low for exactly one cycle when vdata_out has just been updated.
- vdata_out  out  4+3*color_width  {sync[3:0], R, G, B} with sync = {nVSYNC, nCLAMP, nHSYNC, nCSYNC}.
- vmode  out  1  1 = PAL (50 Hz), 0 = NTSC.
- n64_480i  out  1  1 = interlaced source.

## Operation
- Phase counter ph (2 bits plus an idle flag) tracks the bus position.
  - nDSYNC sampled low: ph <= 0, sync_cap <= D_i[3:0]. The idle flag is cleared.
  - nDSYNC sampled high at ph 0: R_cap <= D_i, ph <= 1.
  - nDSYNC sampled high at ph 1: G_cap <= D_i, ph <= 2.
  - nDSYNC sampled high at ph 2: commit, ph <= 3.
- Commit: vdata_out <= {sync_cap, R_cap, G_cap, D_i} and nVDSYNC <= 0. In every other cycle nVDSYNC <= 1.
- nDSYNC high at ph 3: the idle flag is set and no further commits happen until the next nDSYNC low.
- Early nDSYNC low (before the commit) restarts at ph 0. The partial word is discarded and no commit occurs.
- A stream that is never framed (nDSYNC stuck high after reset) produces no commits.
- Line counter lcnt (10 bits, saturating at 1023) is evaluated only at commit. It compares the new sync_cap with the old vdata_out sync bits.
  - nHSYNC rising edge (old 0, new 1): lcnt increments.
  - nVSYNC rising edge: the field closes, and lcnt <= 0 in that same commit. A simultaneous nHSYNC rise is not counted.
- Field close with lcnt >= min_field_lines:
  - vmode <= (lcnt > vmode_thresh).
  - n64_480i <= (lcnt != prev_lcnt).
  - prev_lcnt <= lcnt.
- Field close with lcnt < min_field_lines: vmode, n64_480i and prev_lcnt are unchanged.
- Reset values:
  - vdata_out = 0, nVDSYNC = 1, vmode = 0, n64_480i = 0.
  - lcnt = 0, prev_lcnt = 0, ph = idle.
  - All capture registers = 0.
- Reset asserted mid-word returns everything to the reset values immediately. The first commit after release requires a fresh nDSYNC low.

## Timing
- Standard cadence: nDSYNC low once every 4 VCLK cycles. Sync is sampled at edge E0, R at E1, G at E2, and B at E3.
- At E3, vdata_out updates and nVDSYNC goes low, returning high at E4.
- Latency from the sync nibble sample to a valid vdata_out is 3 cycles.
- Downstream samples vdata_out on the edge where it sees nVDSYNC low. vdata_out then stays stable for at least 3 further cycles at the standard cadence.
- Field-close flag updates take effect in the same cycle as the committing vdata_out. vmode and n64_480i are registered, glitch-free, and change only at field close.
- Back-to-back nDSYNC lows (2-cycle frames) produce no commits. Each low re-captures sync.

## Test plan
- Reset then 4-cycle frames with D_i = 0x0F, 0x11, 0x22, 0x33 -> 3 cycles after the sync sample, vdata_out = {4'hF, 7'h11, 7'h22, 7'h33} and nVDSYNC is low for exactly 1 cycle, once per frame.
- nDSYNC re-asserted at ph 1 with a new sync of 0x5 -> no commit for the aborted word. The next full frame commits sync 0x5 and nVDSYNC pulses only once.
- Fields of 262 and 263 hsync rises, alternating -> vmode = 0 and n64_480i = 1 from the second field close. Constant 262 lines -> n64_480i = 0.
- Constant 312-line fields -> vmode = 1 at the first field close. A switch to 262-line fields -> vmode = 0 at the next close.
- A 50-line glitch field between two 312-line fields -> vmode stays 1, n64_480i stays 0, and prev_lcnt remains 312.
- nRST pulsed low mid-frame at ph 2 -> vdata_out = 0, nVDSYNC = 1 and vmode = 0 asynchronously. No commit occurs until a new nDSYNC low is followed by 3 data cycles.

Source files
------------

// File: rtl/n64_vdemux.sv
// n64_vdemux: front-end demultiplexer for the N64 7-bit video bus.
//
// The video bus carries one word per frame. Each frame is four cycles long and
// is marked by nDSYNC. The sync nibble, R, G and B are captured in turn and
// committed as one parallel word. A one-cycle low nVDSYNC strobe marks each
// commit. Counting nHSYNC rises between nVSYNC rises gives the line count of a
// field, which classifies the source as PAL/NTSC and as interlaced or not.
//
// Ports:
//   VCLK      in   video clock; all logic on its rising edge
//   nRST      in   asynchronous active-low reset
//   nDSYNC    in   frame marker; low marks the sync-nibble cycle
//   D_i       in   video data bus (color_width bits)
//   nVDSYNC   out  low for one cycle right after vdata_out is updated
//   vdata_out out  {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R, G, B}
//   vmode     out  1 = PAL (50 Hz), 0 = NTSC
//   n64_480i  out  1 = interlaced source
module n64_vdemux #(
  parameter int unsigned color_width     = 7,
  parameter int unsigned vmode_thresh    = 290,
  parameter int unsigned min_field_lines = 200
) (
  input  logic                         VCLK,
  input  logic                         nRST,
  input  logic                         nDSYNC,
  input  logic [color_width-1:0]       D_i,
  output logic                         nVDSYNC,
  output logic [4+3*color_width-1:0]   vdata_out,
  output logic                         vmode,
  output logic                         n64_480i
);

  localparam int unsigned VW         = 4 + 3 * color_width;
  localparam logic [9:0]  THRESH_C   = 10'(vmode_thresh);
  localparam logic [9:0]  MIN_C      = 10'(min_field_lines);
  localparam logic [9:0]  LCNT_MAX_C = 10'h3FF;

  logic [1:0]             ph_q, ph_d;
  logic                   idle_q, idle_d;
  logic [3:0]             sync_cap_q, sync_cap_d;
  logic [color_width-1:0] r_cap_q, r_cap_d;
  logic [color_width-1:0] g_cap_q, g_cap_d;
  logic [VW-1:0]          vdata_q, vdata_d;
  logic                   nvdsync_q, nvdsync_d;
  logic [9:0]             lcnt_q, lcnt_d;
  logic [9:0]             prev_lcnt_q, prev_lcnt_d;
  logic                   vmode_q, vmode_d;
  logic                   n480i_q, n480i_d;
  logic                   commit_s;
  logic                   vs_rise_s;
  logic                   hs_rise_s;

  // Edges compare the nibble about to be committed against the last committed
  // one; bit 3 is nVSYNC and bit 1 is nHSYNC.
  assign vs_rise_s = ~vdata_q[VW-1] & sync_cap_q[3];
  assign hs_rise_s = ~vdata_q[VW-3] & sync_cap_q[1];

  // Next-state logic: bus phase tracking, word capture/commit, line counting.
  always_comb begin
    ph_d        = ph_q;
    idle_d      = idle_q;
    sync_cap_d  = sync_cap_q;
    r_cap_d     = r_cap_q;
    g_cap_d     = g_cap_q;
    vdata_d     = vdata_q;
    nvdsync_d   = 1'b1;
    lcnt_d      = lcnt_q;
    prev_lcnt_d = prev_lcnt_q;
    vmode_d     = vmode_q;
    n480i_d     = n480i_q;
    commit_s    = 1'b0;

    // A low nDSYNC always restarts the word, which discards any partial capture.
    if (!nDSYNC) begin
      ph_d       = 2'd0;
      idle_d     = 1'b0;
      sync_cap_d = D_i[3:0];
    end else if (!idle_q) begin
      case (ph_q)
        2'd0: begin
          r_cap_d = D_i;
          ph_d    = 2'd1;
        end
        2'd1: begin
          g_cap_d = D_i;
          ph_d    = 2'd2;
        end
        2'd2: begin
          commit_s = 1'b1;
          ph_d     = 2'd3;
        end
        2'd3: begin
          // Past the end of the word: wait for the next frame marker.
          idle_d = 1'b1;
        end
        default: begin
          idle_d = 1'b1;
        end
      endcase
    end else begin
      ph_d = ph_q;
    end

    if (commit_s) begin
      vdata_d   = {sync_cap_q, r_cap_q, g_cap_q, D_i};
      nvdsync_d = 1'b0;
      // A field close takes priority; a simultaneous hsync rise is not counted.
      if (vs_rise_s) begin
        lcnt_d = 10'd0;
        // Short (glitch) fields leave the classification untouched.
        if (lcnt_q >= MIN_C) begin
          vmode_d     = (lcnt_q > THRESH_C);
          n480i_d     = (lcnt_q != prev_lcnt_q);
          prev_lcnt_d = lcnt_q;
        end else begin
          prev_lcnt_d = prev_lcnt_q;
        end
      end else if (hs_rise_s) begin
        if (lcnt_q != LCNT_MAX_C) begin
          lcnt_d = lcnt_q + 10'd1;
        end else begin
          lcnt_d = lcnt_q;
        end
      end else begin
        lcnt_d = lcnt_q;
      end
    end else begin
      vdata_d = vdata_q;
    end
  end

  // State registers; reset parks the phase tracker idle until a frame marker.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      ph_q        <= 2'd3;
      idle_q      <= 1'b1;
      sync_cap_q  <= 4'd0;
      r_cap_q     <= '0;
      g_cap_q     <= '0;
      vdata_q     <= '0;
      nvdsync_q   <= 1'b1;
      lcnt_q      <= 10'd0;
      prev_lcnt_q <= 10'd0;
      vmode_q     <= 1'b0;
      n480i_q     <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      idle_q      <= idle_d;
      sync_cap_q  <= sync_cap_d;
      r_cap_q     <= r_cap_d;
      g_cap_q     <= g_cap_d;
      vdata_q     <= vdata_d;
      nvdsync_q   <= nvdsync_d;
      lcnt_q      <= lcnt_d;
      prev_lcnt_q <= prev_lcnt_d;
      vmode_q     <= vmode_d;
      n480i_q     <= n480i_d;
    end
  end

  assign nVDSYNC   = nvdsync_q;
  assign vdata_out = vdata_q;
  assign vmode     = vmode_q;
  assign n64_480i  = n480i_q;

endmodule

// File: tb/tb_n64_vdemux.sv
// Directed testbench for n64_vdemux: word framing, aborted words, idle
// behaviour, field-length classification and asynchronous reset.
module tb_n64_vdemux;

  logic        VCLK;
  logic        nRST;
  logic        nDSYNC;
  logic [6:0]  D_i;
  logic        nVDSYNC;
  logic [24:0] vdata_out;
  logic        vmode;
  logic        n64_480i;

  int n_assert;
  int n_fail;
  int pulses;
  int p0;

  n64_vdemux dut (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .nDSYNC    (nDSYNC),
    .D_i       (D_i),
    .nVDSYNC   (nVDSYNC),
    .vdata_out (vdata_out),
    .vmode     (vmode),
    .n64_480i  (n64_480i)
  );

  // 10 ns video clock.
  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, take the rising edge, sample 1 ns later.
  task automatic cyc(input logic nd, input logic [6:0] d);
    nDSYNC = nd;
    D_i    = d;
    @(posedge VCLK);
    #1;
    if (nVDSYNC === 1'b0) pulses++;
  endtask

  task automatic frame(input logic [3:0] s);
    cyc(1'b0, {3'b000, s});
    cyc(1'b1, 7'h01);
    cyc(1'b1, 7'h02);
    cyc(1'b1, 7'h03);
  endtask

  // Field close: nVSYNC low then back high.
  task automatic vpulse();
    frame(4'h7);
    frame(4'hF);
  endtask

  // n hsync rises followed by a field close.
  task automatic field(input int n);
    for (int i = 0; i < n; i++) begin
      frame(4'hD);
      frame(4'hF);
    end
    vpulse();
  endtask

  task automatic fchk(input string tag, input logic ev, input logic ei);
    chk({tag, "_vmode"}, {31'd0, vmode}, {31'd0, ev});
    chk({tag, "_480i"}, {31'd0, n64_480i}, {31'd0, ei});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    pulses   = 0;
    nRST     = 1'b0;
    nDSYNC   = 1'b1;
    D_i      = 7'h00;
    @(posedge VCLK);
    @(posedge VCLK);
    #1;
    chk("rst_vdata", {7'd0, vdata_out}, 32'd0);
    chk("rst_nvdsync", {31'd0, nVDSYNC}, 32'd1);
    chk("rst_vmode", {31'd0, vmode}, 32'd0);
    chk("rst_480i", {31'd0, n64_480i}, 32'd0);
    nRST = 1'b1;

    // Unframed stream: no commits.
    for (int i = 0; i < 6; i++) cyc(1'b1, 7'h2A);
    chk("unframed_pulses", pulses, 32'd0);

    // First frame: latency 3 cycles from sync sample.
    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h11);
    cyc(1'b1, 7'h22);
    chk("lat_vdata_old", {7'd0, vdata_out}, 32'd0);
    chk("lat_nvd_high", {31'd0, nVDSYNC}, 32'd1);
    cyc(1'b1, 7'h33);
    chk("f1_vdata", {7'd0, vdata_out}, {7'd0, 4'hF, 7'h11, 7'h22, 7'h33});
    chk("f1_nvd_low", {31'd0, nVDSYNC}, 32'd0);

    // Second frame: strobe returns high, data held until the next commit.
    cyc(1'b0, 7'h0A);
    chk("f2_nvd_back", {31'd0, nVDSYNC}, 32'd1);
    chk("f2_hold", {7'd0, vdata_out}, {7'd0, 4'hF, 7'h11, 7'h22, 7'h33});
    cyc(1'b1, 7'h44);
    cyc(1'b1, 7'h55);
    cyc(1'b1, 7'h66);
    chk("f2_vdata", {7'd0, vdata_out}, {7'd0, 4'hA, 7'h44, 7'h55, 7'h66});
    chk("f2_pulses", pulses, 32'd2);

    // nDSYNC stays high past the word: idle, no further commits.
    for (int i = 0; i < 5; i++) cyc(1'b1, 7'h7F);
    chk("idle_pulses", pulses, 32'd2);
    chk("idle_hold", {7'd0, vdata_out}, {7'd0, 4'hA, 7'h44, 7'h55, 7'h66});

    // Back-to-back nDSYNC lows: no commits.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 7'h03);
      cyc(1'b1, 7'h7F);
    end
    chk("b2b_pulses", pulses, 32'd2);

    // Abort at ph 1 and restart with sync 0x5.
    cyc(1'b0, 7'h0C);
    cyc(1'b1, 7'h01);
    cyc(1'b0, 7'h05);
    cyc(1'b1, 7'h12);
    cyc(1'b1, 7'h34);
    cyc(1'b1, 7'h56);
    chk("abort_vdata", {7'd0, vdata_out}, {7'd0, 4'h5, 7'h12, 7'h34, 7'h56});
    chk("abort_pulses", pulses, 32'd3);

    // Short field to start from a clean line count; flags untouched.
    vpulse();
    fchk("short0", 1'b0, 1'b0);

    // NTSC interlaced: alternating 262/263.
    field(262);
    field(263);
    fchk("ntsc_i_2", 1'b0, 1'b1);
    field(262);
    fchk("ntsc_i_3", 1'b0, 1'b1);
    field(262);
    fchk("ntsc_p", 1'b0, 1'b0);

    // PAL then back to NTSC.
    field(312);
    fchk("pal_1", 1'b1, 1'b1);
    field(312);
    fchk("pal_2", 1'b1, 1'b0);
    field(262);
    fchk("back_ntsc", 1'b0, 1'b1);

    // Glitch field between two 312-line fields.
    field(312);
    field(312);
    fchk("pre_glitch", 1'b1, 1'b0);
    field(50);
    fchk("glitch", 1'b1, 1'b0);
    field(312);
    fchk("post_glitch", 1'b1, 1'b0);

    // Threshold and minimum-length boundaries.
    field(290);
    fchk("thr_290", 1'b0, 1'b1);
    field(200);
    fchk("min_200", 1'b0, 1'b1);
    field(199);
    fchk("min_199", 1'b0, 1'b1);
    field(200);
    fchk("min_200b", 1'b0, 1'b0);
    field(291);
    fchk("thr_291", 1'b1, 1'b1);
    chk("field_vdata", {7'd0, vdata_out}, {7'd0, 4'hF, 7'h01, 7'h02, 7'h03});

    // Reset pulsed mid-word at ph 2.
    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h11);
    cyc(1'b1, 7'h22);
    nRST = 1'b0;
    #1;
    chk("arst_vdata", {7'd0, vdata_out}, 32'd0);
    chk("arst_nvd", {31'd0, nVDSYNC}, 32'd1);
    chk("arst_vmode", {31'd0, vmode}, 32'd0);
    chk("arst_480i", {31'd0, n64_480i}, 32'd0);
    @(posedge VCLK);
    #1;
    nRST = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 4; i++) cyc(1'b1, 7'h33);
    chk("post_rst_nocommit", pulses, p0);
    chk("post_rst_vdata", {7'd0, vdata_out}, 32'd0);
    cyc(1'b0, 7'h09);
    cyc(1'b1, 7'h0B);
    cyc(1'b1, 7'h0C);
    cyc(1'b1, 7'h0D);
    chk("post_rst_vdata2", {7'd0, vdata_out}, {7'd0, 4'h9, 7'h0B, 7'h0C, 7'h0D});
    chk("post_rst_pulse", pulses, p0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
